noc_pe_adapter: RTL and testbench

NOC_PE_ADAPTER -- requirements
Module: noc_pe_adapter

---
 rtl/noc_pe_adapter.sv | 157 +++++++++++++++
 tb/tb_noc_pe_adapter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pe_adapter.sv
// Network-interface adapter between a processing element and its NoC switch port.
// Holds one show-ahead TX FIFO of flits and one RX FIFO of payloads, and counts ejected flits lost to RX overflow.
module noc_pe_adapter #(
    parameter int x_coord     = 'd0,
    parameter int y_coord     = 'd0,
    parameter int data_width  = 32,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [x_size-1:0]      s_dest_x,
    input  logic [y_size-1:0]      s_dest_y,
    input  logic [data_width-1:0]  s_data,

    output logic                   o_valid_sw,
    output logic [total_width-1:0] o_data_sw,
    input  logic                   i_ready_sw,

    input  logic                   i_valid_sw,
    input  logic [total_width-1:0] i_data_sw,

    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [data_width-1:0]  m_data,

    output logic [15:0]            drop_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int HW = x_size + y_size;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks; self-addressed flits need no special handling here.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
        $error("noc_pe_adapter: FIFO_DEPTH must be a power of two >= 2");
    end
    if (total_width != HW + data_width) begin : gBadWidth
        $error("noc_pe_adapter: total_width must equal x_size + y_size + data_width");
    end
    if ((x_coord < 0) || (y_coord < 0) ||
        (x_coord >= (1 << x_size)) || (y_coord >= (1 << y_size))) begin : gBadCoord
        $error("noc_pe_adapter: node coordinates do not fit the coordinate fields");
    end

    logic [total_width-1:0] txMem [FIFO_DEPTH];
    logic [AW-1:0]          txWrPtr_q, txWrPtr_d;
    logic [AW-1:0]          txRdPtr_q, txRdPtr_d;
    logic [CW-1:0]          txCnt_q,   txCnt_d;
    logic                   txPush, txPop;
    logic [total_width-1:0] txFlit;

    logic [data_width-1:0]  rxMem [FIFO_DEPTH];
    logic [AW-1:0]          rxWrPtr_q, rxWrPtr_d;
    logic [AW-1:0]          rxRdPtr_q, rxRdPtr_d;
    logic [CW-1:0]          rxCnt_q,   rxCnt_d;
    logic                   rxPush, rxPop, rxFull, rxDrop;
    logic [data_width-1:0]  rxPayload;

    logic [15:0]            dropCnt_q, dropCnt_d;

    logic                   unusedRxDest;

    assign txFlit       = {s_data, s_dest_y, s_dest_x};
    assign rxPayload    = i_data_sw[total_width-1:HW];
    assign unusedRxDest = ^i_data_sw[HW-1:0];

    assign s_ready    = (txCnt_q != DEPTH_C);
    assign o_valid_sw = (txCnt_q != '0);
    assign o_data_sw  = txMem[txRdPtr_q];

    assign rxFull   = (rxCnt_q == DEPTH_C);
    assign m_valid  = (rxCnt_q != '0);
    assign m_data   = rxMem[rxRdPtr_q];
    assign drop_cnt = dropCnt_q;

    always_comb begin
        txPush    = s_valid & s_ready;
        txPop     = o_valid_sw & i_ready_sw;
        txWrPtr_d = txWrPtr_q;
        txRdPtr_d = txRdPtr_q;
        txCnt_d   = txCnt_q;
        if (txPush) begin
            txWrPtr_d = txWrPtr_q + AW'(1);
        end
        if (txPop) begin
            txRdPtr_d = txRdPtr_q + AW'(1);
        end
        case ({txPush, txPop})
            2'b10:   txCnt_d = txCnt_q + CW'(1);
            2'b01:   txCnt_d = txCnt_q - CW'(1);
            default: txCnt_d = txCnt_q;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full RX FIFO can still accept the arriving flit.
    always_comb begin
        rxPop     = m_valid & m_ready;
        rxPush    = i_valid_sw & (~rxFull | rxPop);
        rxDrop    = i_valid_sw & rxFull & ~rxPop;
        rxWrPtr_d = rxWrPtr_q;
        rxRdPtr_d = rxRdPtr_q;
        rxCnt_d   = rxCnt_q;
        dropCnt_d = dropCnt_q;
        if (rxPush) begin
            rxWrPtr_d = rxWrPtr_q + AW'(1);
        end
        if (rxPop) begin
            rxRdPtr_d = rxRdPtr_q + AW'(1);
        end
        case ({rxPush, rxPop})
            2'b10:   rxCnt_d = rxCnt_q + CW'(1);
            2'b01:   rxCnt_d = rxCnt_q - CW'(1);
            default: rxCnt_d = rxCnt_q;
        endcase
        if (rxDrop && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txWrPtr_q <= '0;
            txRdPtr_q <= '0;
            txCnt_q   <= '0;
            rxWrPtr_q <= '0;
            rxRdPtr_q <= '0;
            rxCnt_q   <= '0;
            dropCnt_q <= '0;
        end else begin
            txWrPtr_q <= txWrPtr_d;
            txRdPtr_q <= txRdPtr_d;
            txCnt_q   <= txCnt_d;
            rxWrPtr_q <= rxWrPtr_d;
            rxRdPtr_q <= rxRdPtr_d;
            rxCnt_q   <= rxCnt_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Storage is never read while its occupancy says empty, so it is left unreset.
    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[txWrPtr_q] <= txFlit;
        end
        if (rxPush) begin
            rxMem[rxWrPtr_q] <= rxPayload;
        end
    end

endmodule

// File: tb/tb_noc_pe_adapter.sv
// Self-checking bench for noc_pe_adapter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_noc_pe_adapter;

    localparam int XS = 1;
    localparam int YS = 1;
    localparam int DW = 32;
    localparam int HW = XS + YS;
    localparam int TW = HW + DW;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic [XS-1:0] s_dest_x;
    logic [YS-1:0] s_dest_y;
    logic [DW-1:0] s_data;
    logic          o_valid_sw;
    logic [TW-1:0] o_data_sw;
    logic          i_ready_sw;
    logic          i_valid_sw;
    logic [TW-1:0] i_data_sw;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [15:0]   drop_cnt;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    logic [TW-1:0] txModel [$];
    logic [DW-1:0] rxModel [$];
    int            dropModel = 0;

    bit mTxPush, mTxPop, mRxPop, mRxFull;

    noc_pe_adapter #(
        .x_coord    (0),
        .y_coord    (0),
        .data_width (DW),
        .x_size     (XS),
        .y_size     (YS),
        .total_width(TW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_dest_x  (s_dest_x),
        .s_dest_y  (s_dest_y),
        .s_data    (s_data),
        .o_valid_sw(o_valid_sw),
        .o_data_sw (o_data_sw),
        .i_ready_sw(i_ready_sw),
        .i_valid_sw(i_valid_sw),
        .i_data_sw (i_data_sw),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFOs as queues, decisions taken from the occupancy before the edge.
    always @(posedge clk) begin
        if (rstn) begin
            mTxPush = s_valid && (txModel.size() < D);
            mTxPop  = (txModel.size() != 0) && i_ready_sw;
            mRxPop  = (rxModel.size() != 0) && m_ready;
            mRxFull = (rxModel.size() == D);
            if (mTxPop) void'(txModel.pop_front());
            if (mTxPush) txModel.push_back({s_data, s_dest_y, s_dest_x});
            if (mRxPop) void'(rxModel.pop_front());
            if (i_valid_sw) begin
                if (!mRxFull || mRxPop) rxModel.push_back(i_data_sw[TW-1:HW]);
                else if (dropModel < 65535) dropModel++;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn && rstn) begin
            checkOutput("s_ready", s_ready, txModel.size() < D);
            checkOutput("o_valid_sw", o_valid_sw, txModel.size() != 0);
            if (txModel.size() != 0) checkOutput("o_data_sw", o_data_sw, txModel[0]);
            checkOutput("m_valid", m_valid, rxModel.size() != 0);
            if (rxModel.size() != 0) checkOutput("m_data", m_data, rxModel[0]);
            checkOutput("drop_cnt", drop_cnt, dropModel);
        end
    end

    task automatic applyStimulus(input logic sv, input logic [XS-1:0] dx, input logic [YS-1:0] dy,
                                 input logic [DW-1:0] sd, input logic irdy, input logic iv,
                                 input logic [TW-1:0] idata, input logic mrdy);
        s_valid    = sv;
        s_dest_x   = dx;
        s_dest_y   = dy;
        s_data     = sd;
        i_ready_sw = irdy;
        i_valid_sw = iv;
        i_data_sw  = idata;
        m_ready    = mrdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; outputs must clear before any further edge.
    task automatic doReset();
        rstn       = 1'b0;
        s_valid    = 1'b0;
        i_valid_sw = 1'b0;
        txModel.delete();
        rxModel.delete();
        dropModel = 0;
        #1;
        checkOutput("rst_o_valid_sw", o_valid_sw, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        nextCycle();
        nextCycle();
        rstn = 1'b1;
    endtask

    logic [TW-1:0] expFlit;

    initial begin
        rstn = 1'b0;
        applyStimulus(0, '0, '0, '0, 0, 0, '0, 0);
        nextCycle();
        doReset();
        checkEn = 1'b1;

        // Single flit to dest (1,0) is visible one cycle after the write and popped immediately.
        applyStimulus(1, 1'b1, 1'b0, 32'hA5A5A5A5, 1, 0, '0, 0);
        nextCycle();
        expFlit = {32'hA5A5A5A5, 1'b0, 1'b1};
        checkOutput("tx_latency_valid", o_valid_sw, 1);
        checkOutput("tx_flit_format", o_data_sw, expFlit);
        s_valid = 1'b0;
        nextCycle();
        checkOutput("tx_popped", o_valid_sw, 0);

        // Fill TX under backpressure, then drain back-to-back.
        i_ready_sw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid  = 1'b1;
            s_dest_x = XS'(k & 1);
            s_dest_y = YS'((k >> 1) & 1);
            s_data   = 32'h1000 + DW'(k);
            nextCycle();
            checkOutput("tx_fill_sready", s_ready, (k < 3) ? 1 : 0);
        end
        s_valid = 1'b0;
        checkOutput("model_tx_full", txModel.size(), 4);
        i_ready_sw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expFlit = {32'h1000 + DW'(k), YS'((k >> 1) & 1), XS'(k & 1)};
            checkOutput("tx_drain_valid", o_valid_sw, 1);
            checkOutput("tx_drain_order", o_data_sw, expFlit);
            nextCycle();
            if (k == 0) checkOutput("tx_sready_after_pop", s_ready, 1);
        end
        checkOutput("tx_drained", o_valid_sw, 0);
        i_ready_sw = 1'b0;

        // Six ejected flits into a depth-4 RX with the PE stalled: two are dropped.
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_valid_sw = 1'b1;
            i_data_sw  = {32'hB000 + DW'(k), 2'b11};
            nextCycle();
            if (k == 0) checkOutput("rx_latency_valid", m_valid, 1);
        end
        i_valid_sw = 1'b0;
        checkOutput("rx_full_valid", m_valid, 1);
        checkOutput("rx_drop_two", drop_cnt, 2);
        checkOutput("rx_head", m_data, 32'hB000);
        checkOutput("model_drop_two", dropModel, 2);

        // Arrival on a full RX with a same-cycle pop is accepted, not dropped.
        i_valid_sw = 1'b1;
        i_data_sw  = {32'hB006, 2'b00};
        m_ready    = 1'b1;
        nextCycle();
        i_valid_sw = 1'b0;
        m_ready    = 1'b0;
        checkOutput("rx_pushpop_no_drop", drop_cnt, 2);
        checkOutput("rx_pushpop_head", m_data, 32'hB001);
        checkOutput("model_rx_still_full", rxModel.size(), 4);
        m_ready = 1'b1;
        nextCycle();
        checkOutput("rx_drain_b002", m_data, 32'hB002);
        nextCycle();
        m_ready = 1'b0;
        checkOutput("rx_drain_b003", m_data, 32'hB003);

        // Reset with 3 TX and 2 RX entries buffered.
        i_ready_sw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 32'hC000 + DW'(k);
            nextCycle();
        end
        s_valid = 1'b0;
        checkOutput("pre_rst_o_valid", o_valid_sw, 1);
        checkOutput("pre_rst_m_valid", m_valid, 1);
        checkOutput("pre_rst_drop", drop_cnt, 2);
        doReset();
        i_ready_sw = 1'b1;
        m_ready    = 1'b1;
        repeat (5) nextCycle();
        checkOutput("post_rst_no_tx", o_valid_sw, 0);
        checkOutput("post_rst_no_rx", m_valid, 0);

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(($urandom_range(0, 1) == 1), XS'($urandom_range(0, 1)), YS'($urandom_range(0, 1)),
                          DW'($urandom()), ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
                          {DW'($urandom()), HW'($urandom_range(0, 3))}, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 499) == 0) doReset();
            else nextCycle();
        end

        // Drop counter saturation: fill RX, then force 65540 drops.
        doReset();
        applyStimulus(0, '0, '0, '0, 1, 1, '0, 0);
        for (int k = 0; k < 65544; k++) begin
            i_data_sw = {DW'(k), 2'b01};
            nextCycle();
        end
        i_valid_sw = 1'b0;
        nextCycle();
        checkOutput("drop_saturated", drop_cnt, 16'hFFFF);
        checkOutput("model_drop_saturated", dropModel, 65535);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
